// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDOp encodings (MD_*): the operation launched by Start.
//   - HiLoWr encodings (HILO_*): the direct HI/LO writes used by mthi/mtlo.
//   - Default latencies for the multiply and divide paths.
//   - hilo_t: a {HI,LO} pair as produced by the arithmetic core.
package mul_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_HI   = 2'b01;
    localparam logic [1:0] HILO_LO   = 2'b10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Divide operations share the MSB of the opcode.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_md_core.sv
// Purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   op     in   2   operation (MD_MULT / MD_MULTU / MD_DIV / MD_DIVU)
//   a      in   32  rs operand (dividend / multiplicand)
//   b      in   32  rt operand (divisor / multiplier)
//   result out  64  {HI,LO} value to commit
//   hold   out  1   divide by zero: HI/LO must keep their old contents
module mul_div_unit_md_core
    import mul_div_unit_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       result,
    output logic        hold
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // The low 64 bits of the product of the sign-extended operands equal the
    // two's complement signed product, so one plain multiplier serves both.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes and fixes the signs afterwards:
    // quotient negative when signs differ, remainder follows the dividend.
    // 0x80000000 has magnitude 0x80000000 unsigned, so the -2^31 / -1 case
    // yields quotient 0x80000000 and remainder 0 without special handling.
    assign a_neg = (op == MD_DIV) && a[31];
    assign b_neg = (op == MD_DIV) && b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;
    // Substitute a harmless divisor on zero; the result is discarded via hold.
    assign b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;

    always_comb begin
        result = '0;
        hold   = 1'b0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            default: begin
                result.lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
                result.hi = a_neg ? (32'd0 - r_mag) : r_mag;
                hold      = (b == 32'd0);
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers in EX.
// Ports:
//   clk       in   1   clock, all state changes on the rising edge
//   rst_n     in   1   synchronous active-low reset
//   Start     in   1   launch the operation in MDOp (one-cycle pulse)
//   MDOp      in   2   00 mult, 01 multu, 10 div, 11 divu
//   A         in   32  rs operand (also the mthi/mtlo source)
//   B         in   32  rt operand
//   HiLoWr    in   2   01 HI<=A, 10 LO<=A, 00/11 no write
//   Busy      out  1   operation in flight
//   HI        out  32  HI register
//   LO        out  32  LO register
//   dbg_state out  1   FSM state (0 IDLE, 1 RUN) for observation
//
// Start/Busy handshake: Start is sampled only while Busy=0 (IDLE). A Start
// accepted at edge T raises Busy for cycles T+1..T+N; the edge ending cycle
// T+N commits HI/LO. Start seen while Busy=1 is dropped; the hazard unit is
// expected never to issue one. HiLoWr is likewise only honoured in IDLE, and
// Start takes priority over HiLoWr in the same cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HiLoWr,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    hilo_t            core_result;
    logic             core_hold;

    // The core works from the latched operands so A/B may change during RUN.
    mul_div_unit_md_core u_md_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .hold   (core_hold)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= MD_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        op_q  <= MDOp;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= ST_RUN;
                    end else if (HiLoWr == HILO_HI) begin
                        hi_q <= A;
                    end else if (HiLoWr == HILO_LO) begin
                        lo_q <= A;
                    end
                end
                ST_RUN: begin
                    // cnt==1 marks the last busy cycle: commit on this edge.
                    if (cnt == CNT_W'(1)) begin
                        if (!core_hold) begin
                            hi_q <= core_result.hi;
                            lo_q <= core_result.lo;
                        end
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy      = (state == ST_RUN);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios from the block's
// behaviour list plus randomized operations against an arithmetic model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;
    localparam int WAIT_LIMIT = 200;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  HiLoWr;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        dbg_state;

    always #5 clk = ~clk;

    mul_div_unit #(.MULT_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .MDOp      (MDOp),
        .A         (A),
        .B         (B),
        .HiLoWr    (HiLoWr),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Model of the architectural HI/LO contents.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] exp_q[$];

    // ---------------- reference model ----------------
    // Plain arithmetic on 64-bit integers; division by zero keeps old values.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] old_hi,
                                           input logic [31:0] old_lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        res = {old_hi, old_lo};
        case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
            MD_DIV: begin
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b != 32'd0) res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        m_hi = '0;
        m_lo = '0;
    endtask

    // Counts falling edges with Busy high; returns WAIT_LIMIT on timeout.
    task automatic wait_idle(output int n, output logic stable,
                             input logic [31:0] h0, input logic [31:0] l0);
        n = 0;
        stable = 1'b1;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (!Busy) break;
            n++;
            if (HI !== h0 || LO !== l0) stable = 1'b0;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] wr, output int busy_n, output logic stable);
        logic [31:0] h0, l0;
        h0 = HI;
        l0 = LO;
        Start = 1'b1;
        MDOp = op;
        A = a;
        B = b;
        HiLoWr = wr;
        @(posedge clk);
        #1;
        Start = 1'b0;
        HiLoWr = HILO_NONE;
        wait_idle(busy_n, stable, h0, l0);
    endtask

    task automatic do_write(input logic [1:0] wr, input logic [31:0] a);
        HiLoWr = wr;
        A = a;
        @(posedge clk);
        #1 HiLoWr = HILO_NONE;
        @(negedge clk);
        if (wr == HILO_HI) m_hi = a;
        if (wr == HILO_LO) m_lo = a;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h want 0", LO); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state: got %b want 0", dbg_state); end
    endtask

    task automatic test_mult();
        logic [1:0]  ops[2] = '{MD_MULT, MD_MULTU};
        logic [31:0] as[2]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] bs[2]  = '{32'd3, 32'hFFFF_FFFF};
        logic [63:0] ex[2]  = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFE_0000_0001};
        int busy_n;
        logic stable;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], as[i], bs[i], HILO_NONE, busy_n, stable);
            checks++; if (busy_n != MUL_N) begin failures++; $display("FAIL mult_busy[%0d]: got %0d want %0d", i, busy_n, MUL_N); end
            checks++; if ({HI, LO} !== ex[i]) begin failures++; $display("FAIL mult_result[%0d]: got %h want %h", i, {HI, LO}, ex[i]); end
            checks++; if (!stable) begin failures++; $display("FAIL mult_hold_during_run[%0d]: got changed want stable", i); end
            {m_hi, m_lo} = ex[i];
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops[4] = '{MD_DIV, MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'd7};
        logic [31:0] bs[4]  = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
        logic [63:0] ex[4]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000,
                                64'h0000_0001_0000_0003, 64'h0000_0001_FFFF_FFFD};
        int busy_n;
        logic stable;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], HILO_NONE, busy_n, stable);
            checks++; if (busy_n != DIV_N) begin failures++; $display("FAIL div_busy[%0d]: got %0d want %0d", i, busy_n, DIV_N); end
            checks++; if ({HI, LO} !== ex[i]) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, {HI, LO}, ex[i]); end
            {m_hi, m_lo} = ex[i];
        end
    endtask

    task automatic test_div_zero();
        int busy_n;
        logic stable;
        do_write(HILO_HI, 32'h11);
        checks++; if (HI !== 32'h11) begin failures++; $display("FAIL mthi_write: got %h want 11", HI); end
        do_write(HILO_LO, 32'h22);
        checks++; if (LO !== 32'h22) begin failures++; $display("FAIL mtlo_write: got %h want 22", LO); end
        do_op(MD_DIVU, 32'd7, 32'd0, HILO_NONE, busy_n, stable);
        checks++; if (busy_n != DIV_N) begin failures++; $display("FAIL divu0_busy: got %0d want %0d", busy_n, DIV_N); end
        checks++; if ({HI, LO} !== 64'h11_0000_0022) begin failures++; $display("FAIL divu0_hold: got %h want %h", {HI, LO}, 64'h11_0000_0022); end
        do_op(MD_DIV, 32'h8000_0000, 32'd0, HILO_NONE, busy_n, stable);
        checks++; if ({HI, LO} !== 64'h11_0000_0022) begin failures++; $display("FAIL div0_hold: got %h want %h", {HI, LO}, 64'h11_0000_0022); end
    endtask

    task automatic test_hilo_writes();
        do_write(HILO_HI, 32'hA5A5_0001);
        checks++; if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL mthi_only_hi: got %h want %h", {HI, LO}, {m_hi, m_lo}); end
        do_write(2'b11, 32'hDEAD_BEEF);
        checks++; if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL hilowr11_none: got %h want %h", {HI, LO}, {m_hi, m_lo}); end
    endtask

    // mthi issued while a multiply runs must be dropped.
    task automatic test_hilowr_during_run();
        int busy_n;
        logic stable;
        logic [31:0] h0, l0;
        h0 = HI;
        l0 = LO;
        Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd4;
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        HiLoWr = HILO_HI; A = 32'h1234;
        @(posedge clk);
        #1 HiLoWr = HILO_NONE;
        @(negedge clk);
        checks++; if (HI !== h0) begin failures++; $display("FAIL mthi_in_run: got %h want %h", HI, h0); end
        wait_idle(busy_n, stable, h0, l0);
        checks++; if (busy_n + 2 != MUL_N || !stable) begin failures++; $display("FAIL mthi_in_run_busy: got %0d want %0d", busy_n + 2, MUL_N); end
        checks++; if ({HI, LO} !== 64'd12) begin failures++; $display("FAIL mthi_in_run_result: got %h want %h", {HI, LO}, 64'd12); end
        {m_hi, m_lo} = 64'd12;
    endtask

    // A second Start during RUN is ignored; the first op completes on time.
    task automatic test_start_while_busy();
        int busy_n;
        logic stable;
        Start = 1'b1; MDOp = MD_MULTU; A = 32'd100; B = 32'd5;
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        Start = 1'b1; MDOp = MD_DIVU; A = 32'd9; B = 32'd2;
        @(posedge clk);
        #1 Start = 1'b0;
        wait_idle(busy_n, stable, HI, LO);
        checks++; if (busy_n + 1 != MUL_N) begin failures++; $display("FAIL start_busy_len: got %0d want %0d", busy_n + 1, MUL_N); end
        checks++; if ({HI, LO} !== 64'd500) begin failures++; $display("FAIL start_busy_result: got %h want %h", {HI, LO}, 64'd500); end
        {m_hi, m_lo} = 64'd500;
    endtask

    task automatic test_start_with_hilowr();
        int busy_n;
        logic stable;
        do_op(MD_MULTU, 32'd6, 32'd7, HILO_LO, busy_n, stable);
        checks++; if ({HI, LO} !== 64'd42) begin failures++; $display("FAIL start_wins_lo: got %h want %h", {HI, LO}, 64'd42); end
        {m_hi, m_lo} = 64'd42;
    endtask

    task automatic test_reset_mid_run();
        logic clean;
        do_write(HILO_HI, 32'h55);
        Start = 1'b1; MDOp = MD_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrun_reset_busy: got %b want 0", Busy); end
        checks++; if ({HI, LO} !== 64'd0) begin failures++; $display("FAIL midrun_reset_hilo: got %h want 0", {HI, LO}); end
        clean = 1'b1;
        repeat (DIV_N + 5) begin
            @(negedge clk);
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) clean = 1'b0;
        end
        checks++; if (!clean) begin failures++; $display("FAIL midrun_reset_no_commit: got late activity want none"); end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[4] = '{MD_MULT, MD_DIV, MD_MULTU, MD_DIVU};
        int busy_n;
        logic stable;
        logic [31:0] a, b;
        logic [63:0] got;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            exp_q.push_back(ref_md(ops[i], a, b, m_hi, m_lo));
            do_op(ops[i], a, b, HILO_NONE, busy_n, stable);
            got = {HI, LO};
            {m_hi, m_lo} = exp_q.pop_front();
            checks++; if (got !== {m_hi, m_lo}) begin failures++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got, {m_hi, m_lo}); end
        end
    endtask

    task automatic test_random();
        int busy_n;
        logic stable;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] got;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                op = 2'($urandom_range(0, 3));
                do_write(op, $urandom);
                checks++; if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL rand_write[%0d]: got %h want %h", i, {HI, LO}, {m_hi, m_lo}); end
            end else begin
                op = 2'($urandom_range(0, 3));
                a = $urandom;
                case ($urandom_range(0, 7))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = 32'($urandom_range(1, 16));
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
                exp_q.push_back(ref_md(op, a, b, m_hi, m_lo));
                do_op(op, a, b, HILO_NONE, busy_n, stable);
                got = {HI, LO};
                {m_hi, m_lo} = exp_q.pop_front();
                checks++; if (got !== {m_hi, m_lo}) begin failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, got, {m_hi, m_lo}); end
                checks++; if (busy_n != (op[1] ? DIV_N : MUL_N)) begin failures++; $display("FAIL rand_busy[%0d]: got %0d want %0d", i, busy_n, op[1] ? DIV_N : MUL_N); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        Start = 1'b0;
        MDOp = MD_MULT;
        A = '0;
        B = '0;
        HiLoWr = HILO_NONE;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_hilo_writes();
        test_hilowr_during_run();
        test_start_while_busy();
        test_start_with_hilowr();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
